dmem_arbiter: RTL

//   Shares the single-port data RAM between the CPU load/store path and a

---
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/debug arbiter in front of a single-port data RAM
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  // CPU load/store port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // debug/loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  // status
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

  // owner / last_grant encoding: 0 = CPU, 1 = debug
  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                busy_q, busy_d;

  // Winner selection: a lone requester wins; on a tie the side that did
  // not get the previous grant wins, which makes grants alternate.
  logic                grant_dbg;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign grant_dbg = dbg_req & (~cpu_req | ~last_grant_q);
  assign sel_we    = grant_dbg ? dbg_we    : cpu_we;
  assign sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
  assign sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    cpu_ack_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req | dbg_req) begin
          // The RAM-facing registers double as the latched request so the
          // address reaches the RAM in the very next cycle.
          state_d      = S_ISSUE;
          owner_d      = grant_dbg;
          last_grant_d = grant_dbg;
          we_d         = sel_we;
          ram_addr_d   = sel_addr;
          ram_data_d   = sel_wdata;
          ram_wren_d   = sel_we;
        end
      end

      S_ISSUE: begin
        if (we_q) begin
          state_d   = S_ACK;
          cpu_ack_d = ~owner_q;
          dbg_ack_d = owner_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          // ram_q becomes valid exactly on the last wait cycle
          state_d = S_ACK;
          if (owner_q) begin
            dbg_rdata_d = ram_q;
            dbg_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = ram_q;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_wren  = ram_wren_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

  // The PC freezes for as long as a CPU access is outstanding
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
